ctrl_pipe_stage: RTL and testbench
==================================

Name: ctrl_pipe_stage

Overview:
- Parametrised, elastic control-bundle pipeline register that replaces fixed per-stage control buffers.
- Carries a WIDTH-bit control word (memory read/write enables, writeback select, register-file enable, CSR read/write) through DEPTH register slots.
- Provides valid/ready handshake, global stall (hold), per-slot flush (bubble insertion), occupancy reporting and a saturating starvation counter.
- Sits between the decode/execute and memory/writeback control paths of the RISC-V pipeline.

Parameters:
- WIDTH, 7, control word width (default is the ctrl_bundle_t width).
- DEPTH, 1, number of register slots; legal range 1..4.
- BUBBLE_VAL, '0, control word held by an empty or flushed slot. All enables are 0, which makes it a NOP.
- CNT_W, 16, starvation counter width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream control word valid
- in_ready  out  1  slot 0 can accept this cycle
- in_ctrl  in  WIDTH  upstream control word
- stall  in  1  hold all slots (hazard stall)
- flush  in  DEPTH  per-slot kill; bit i kills slot i
- out_valid  out  1  slot DEPTH-1 valid
- out_ready  in  1  downstream accepts
- out_ctrl  out  WIDTH  control word of slot DEPTH-1
- cnt_clr  in  1  synchronous clear of bubble_cnt
- bubble_cnt  out  CNT_W  cycles in which the output was starved
- occupancy  out  $clog2(DEPTH+1)  number of valid slots

Behaviour:
- Reset is asynchronous: every v_i=0, every d_i=BUBBLE_VAL, bubble_cnt=0. So out_valid=0, out_ctrl=BUBBLE_VAL, occupancy=0.
  - Every register is reset, including the writeback-select field.
- Invariant: v_i=0 implies d_i=BUBBLE_VAL at all times.
- Ready chain (combinational):
  - rdy_DEPTH = out_ready & ~stall
  - rdy_i = ~v_i | rdy_(i+1)
  - in_ready = rdy_0 & ~stall
- Slot i, without flush, at the clock edge:
  - If rdy_i and not stall: load from upstream. The upstream is slot i-1, or in_valid/in_ctrl for i=0. The valid bit is the upstream valid; data is the upstream data, or BUBBLE_VAL when upstream is invalid.
  - Otherwise: hold.
- Flush:
  - flush[i] forces v_i=0 and d_i=BUBBLE_VAL at the edge.
  - Flush overrides stall and overrides any word moving into slot i; that word is discarded.
  - The transfer out of slot i-1 still completes: slot i-1 refills or empties as if the handshake succeeded.
  - For i=0, an accepted input (in_valid & in_ready) is consumed and discarded.
  - flush does not affect in_ready (no combinational path from flush to in_ready).
- Stall:
  - All slots hold, except flushed slots.
  - in_ready=0.
  - out_valid still reflects slot DEPTH-1, but no output transfer occurs because rdy_DEPTH=0.
- Timing:
  - Latency with no stall, backpressure or flush is DEPTH cycles from the in_valid&in_ready edge to out_valid.
  - Throughput is 1 word per cycle, including when full with out_ready=1 (pass-through ready chain).
- Outputs:
  - out_valid=v_(DEPTH-1), out_ctrl=d_(DEPTH-1); both are registered.
  - occupancy = popcount(v), combinational from registers.
- bubble_cnt:
  - Increments by 1 at each edge where out_ready=1, out_valid=0 and stall=0.
  - Saturates at all-ones (no wrap).
  - cnt_clr has priority over increment and forces 0 at the next edge.
- Reset mid-operation discards all contents immediately (asynchronous). The first accept after deassertion behaves as from empty.

Decomposition:
- Package ctrl_pipe_pkg:
  - ctrl_bundle_t: packed struct rd_en, wr_en, wb_sel[1:0], rf_en, csr_rd, csr_wr.
  - CTRL_W = $bits(ctrl_bundle_t).
  - CTRL_NOP constant (all zero), used as BUBBLE_VAL.
  - MAX_DEPTH=4.
- Sub-module ctrl_pipe_slot: one valid+data register with load/hold/flush, reset to BUBBLE_VAL. Generated DEPTH times.
- Counter and ready chain stay in the top module.

Test Plan:
- Reset: assert rst mid-stream with DEPTH=2 holding 2 words -> immediately out_valid=0, out_ctrl=0, occupancy=0, bubble_cnt=0.
- Streaming: DEPTH=2, out_ready=1, in_valid=1 with words 0x11, 0x22, 0x33 on consecutive cycles -> out_ctrl 0x11 valid 2 cycles after the first accept, then 0x22 and 0x33 back-to-back; in_ready stays 1.
- Backpressure: DEPTH=3, out_ready=0, push 4 words -> in_ready drops after 3 accepts, occupancy=3. Raise out_ready -> the words drain in order with no loss or duplication.
- Stall plus flush: DEPTH=2, full, stall=1, flush=2'b10 -> slot 1 empties (out_valid=0, out_ctrl=0), slot 0 holds, in_ready=0, occupancy=1.
- Flush of input: flush[0]=1 with in_valid=1, in_ready=1, in_ctrl=0x7F -> word accepted but slot 0 stays empty; it never appears at the output.
- Counter: CNT_W=3, out_ready=1, no input for 10 cycles -> bubble_cnt saturates at 7. Pulse cnt_clr -> 0 next cycle. With stall=1 the counter does not increment.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// Shared types and constants for the elastic control-bundle pipeline register.
package ctrl_pipe_pkg;

  // Control word carried from decode/execute towards memory/writeback.
  typedef struct packed {
    logic       rd_en;   // memory read enable
    logic       wr_en;   // memory write enable
    logic [1:0] wb_sel;  // writeback source select
    logic       rf_en;   // register-file write enable
    logic       csr_rd;  // CSR read
    logic       csr_wr;  // CSR write
  } ctrl_bundle_t;

  localparam int CTRL_W = $bits(ctrl_bundle_t);

  // All enables low: a bubble that has no architectural side effect.
  localparam ctrl_bundle_t CTRL_NOP = '0;

  // Largest supported number of register slots.
  localparam int MAX_DEPTH = 4;

endpackage : ctrl_pipe_pkg

// File: rtl/ctrl_pipe_slot.sv
// One valid+data register slot with flush, load and hold.
// An empty slot always carries BUBBLE_VAL so a stale word can never leak out.
module ctrl_pipe_slot
  import ctrl_pipe_pkg::*;
#(
  parameter int               WIDTH      = CTRL_W,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,      // take the upstream word this edge
  input  logic             flush,     // kill this slot this edge
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Slot register: flush beats load, load beats hold.
  // NOTE: sequential state uses non-blocking assignments so every slot samples
  // its upstream neighbour's pre-edge value, giving a true shift.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the data field is reset too (not just valid) so the output word is a
    // known NOP straight out of reset, not whatever the flops powered up with.
    if (rst) begin
      valid <= 1'b0;
      data  <= BUBBLE_VAL;
    end else if (flush) begin
      valid <= 1'b0;
      data  <= BUBBLE_VAL;
    end else if (load) begin
      valid <= up_valid;
      data  <= up_valid ? up_data : BUBBLE_VAL;
    end
  end

endmodule : ctrl_pipe_slot

// File: rtl/ctrl_pipe_stage.sv
// Elastic control-bundle pipeline register: DEPTH slots with a pass-through
// ready chain, global stall, per-slot flush, occupancy and starvation counter.
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int               WIDTH      = CTRL_W,
  parameter int               DEPTH      = 1,       // 1..MAX_DEPTH
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
  parameter int               CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_ctrl,
  input  logic                       stall,
  input  logic [DEPTH-1:0]           flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_ctrl,
  input  logic                       cnt_clr,
  output logic [CNT_W-1:0]           bubble_cnt,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v;            // per-slot valid
  logic [WIDTH-1:0] d [DEPTH];    // per-slot data
  logic [DEPTH-1:0] rdy;          // slot i may accept a word this cycle
  logic             out_rdy;      // downstream side of the last slot
  logic [DEPTH-1:0] load;

  // Ready chain: a slot is ready if it is empty or everything after it moves.
  // Built as a running term so the chain has no self-referencing vector.
  // NOTE: every variable gets a default before any conditional logic so the
  // block stays purely combinational and never infers a latch.
  always_comb begin
    logic chain;
    rdy     = '0;
    out_rdy = out_ready & ~stall;
    chain   = out_rdy;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      chain  = ~v[i] | chain;
      rdy[i] = chain;
    end
  end

  // Stall freezes every slot; flush is applied inside each slot independently,
  // so a flushed slot still lets its upstream neighbour complete its transfer.
  assign load     = rdy & {DEPTH{~stall}};
  assign in_ready = rdy[0] & ~stall;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic             up_v;
    logic [WIDTH-1:0] up_d;

    if (i == 0) begin : g_head
      assign up_v = in_valid;
      assign up_d = in_ctrl;
    end else begin : g_body
      assign up_v = v[i-1];
      assign up_d = d[i-1];
    end

    ctrl_pipe_slot #(
      .WIDTH      (WIDTH),
      .BUBBLE_VAL (BUBBLE_VAL)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load[i]),
      .flush    (flush[i]),
      .up_valid (up_v),
      .up_data  (up_d),
      .valid    (v[i]),
      .data     (d[i])
    );
  end

  assign out_valid = v[DEPTH-1];
  assign out_ctrl  = d[DEPTH-1];

  // Occupancy: population count of the slot valid bits.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(v[i]);
    end
  end

  // Starvation counter: downstream was ready but we had nothing to give.
  // Saturates rather than wrapping; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (cnt_clr) begin
      bubble_cnt <= '0;
    end else if (out_ready && !out_valid && !stall && !(&bubble_cnt)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule : ctrl_pipe_stage

// File: tb/tb_ctrl_pipe_stage.sv
// Scoreboard bench for ctrl_pipe_stage: two instances (DEPTH=2/CNT_W=3 and
// DEPTH=3). Stimulus pushes expected words; monitors pop on every transfer.
module tb_ctrl_pipe_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DEPTH=2, CNT_W=3 instance
  logic       in_valid2 = 0, in_ready2, stall2 = 0, out_valid2, out_ready2 = 0, cnt_clr2 = 0;
  logic [6:0] in_ctrl2 = '0, out_ctrl2;
  logic [1:0] flush2 = '0, occupancy2;
  logic [2:0] bubble_cnt2;

  // DEPTH=3, CNT_W=16 instance
  logic        in_valid3 = 0, in_ready3, stall3 = 0, out_valid3, out_ready3 = 0, cnt_clr3 = 0;
  logic [6:0]  in_ctrl3 = '0, out_ctrl3;
  logic [2:0]  flush3 = '0;
  logic [1:0]  occupancy3;
  logic [15:0] bubble_cnt3;

  ctrl_pipe_stage #(.WIDTH(7), .DEPTH(2), .CNT_W(3)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_ctrl(in_ctrl2),
    .stall(stall2), .flush(flush2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_ctrl(out_ctrl2), .cnt_clr(cnt_clr2), .bubble_cnt(bubble_cnt2), .occupancy(occupancy2)
  );

  ctrl_pipe_stage #(.WIDTH(7), .DEPTH(3), .CNT_W(16)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .in_ctrl(in_ctrl3),
    .stall(stall3), .flush(flush3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_ctrl(out_ctrl3), .cnt_clr(cnt_clr3), .bubble_cnt(bubble_cnt3), .occupancy(occupancy3)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [6:0] exp_q2 [$];
  logic [6:0] exp_q3 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitors: every completed output transfer must match the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid2 && out_ready2) begin
      if (exp_q2.size() == 0) check("d2_unexpected_out", 32'(out_ctrl2), 32'h1ff);
      else                    check("d2_out_ctrl", 32'(out_ctrl2), 32'(exp_q2.pop_front()));
    end
    if (!rst && out_valid3 && out_ready3) begin
      if (exp_q3.size() == 0) check("d3_unexpected_out", 32'(out_ctrl3), 32'h1ff);
      else                    check("d3_out_ctrl", 32'(out_ctrl3), 32'(exp_q3.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    // ---------------- reset state ----------------
    tick(2);
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid2), 0);
    check("rst_out_ctrl",  32'(out_ctrl2), 0);
    check("rst_occupancy", 32'(occupancy2), 0);
    check("rst_bubble",    32'(bubble_cnt2), 0);

    // ---------------- streaming, DEPTH=2 ----------------
    out_ready2 = 1;
    in_valid2 = 1; in_ctrl2 = 7'h11;
    check("str_in_ready0", 32'(in_ready2), 1);
    check("str_lat_c0",    32'(out_valid2), 0);
    exp_q2.push_back(7'h11);
    tick();
    in_ctrl2 = 7'h22;
    check("str_in_ready1", 32'(in_ready2), 1);
    check("str_lat_c1",    32'(out_valid2), 0);
    exp_q2.push_back(7'h22);
    tick();
    in_ctrl2 = 7'h33;
    check("str_in_ready2", 32'(in_ready2), 1);
    check("str_lat_c2",    32'(out_valid2), 1);
    exp_q2.push_back(7'h33);
    tick();
    in_valid2 = 0;
    tick(4);
    check("str_drained", 32'(exp_q2.size()), 0);

    // ---------------- stall + flush, DEPTH=2 ----------------
    out_ready2 = 0;
    in_valid2 = 1; in_ctrl2 = 7'h05;          // lands in slot 1, will be flushed
    tick();
    in_ctrl2 = 7'h0A;                          // lands in slot 0, survives
    exp_q2.push_back(7'h0A);
    tick();
    in_valid2 = 0;
    check("sf_full_occ",   32'(occupancy2), 2);
    check("sf_full_ready", 32'(in_ready2), 0);
    stall2 = 1; flush2 = 2'b10;
    check("sf_stall_ready", 32'(in_ready2), 0);
    tick();
    flush2 = 2'b00;
    check("sf_out_valid", 32'(out_valid2), 0);
    check("sf_out_ctrl",  32'(out_ctrl2), 0);
    check("sf_occ",       32'(occupancy2), 1);
    check("sf_in_ready",  32'(in_ready2), 0);
    stall2 = 0; out_ready2 = 1;
    tick(4);

    // ---------------- flush of accepted input, DEPTH=2 ----------------
    in_valid2 = 1; in_ctrl2 = 7'h7F; flush2 = 2'b01;
    check("fi_in_ready", 32'(in_ready2), 1);
    tick();
    in_valid2 = 0; flush2 = 2'b00;
    check("fi_occ", 32'(occupancy2), 0);
    tick(4);
    check("fi_never_out", 32'(occupancy2), 0);

    // ---------------- starvation counter, CNT_W=3 ----------------
    cnt_clr2 = 1;
    tick();
    cnt_clr2 = 0;
    check("cnt_cleared", 32'(bubble_cnt2), 0);
    tick(3);
    check("cnt_three", 32'(bubble_cnt2), 3);
    tick(7);
    check("cnt_saturate", 32'(bubble_cnt2), 7);
    cnt_clr2 = 1;
    tick();
    cnt_clr2 = 0;
    check("cnt_clr", 32'(bubble_cnt2), 0);
    stall2 = 1;
    tick(3);
    check("cnt_stall_hold", 32'(bubble_cnt2), 0);
    stall2 = 0;
    tick();
    check("cnt_resume", 32'(bubble_cnt2), 1);

    // ---------------- reset mid-stream, DEPTH=2 ----------------
    out_ready2 = 0;
    in_valid2 = 1; in_ctrl2 = 7'h21;
    tick();
    in_ctrl2 = 7'h42;
    tick();
    in_valid2 = 0;
    check("mr_full_occ", 32'(occupancy2), 2);
    #2 rst = 1'b1;
    #1;
    check("mr_out_valid", 32'(out_valid2), 0);
    check("mr_out_ctrl",  32'(out_ctrl2), 0);
    check("mr_occ",       32'(occupancy2), 0);
    check("mr_bubble",    32'(bubble_cnt2), 0);
    tick();
    rst = 1'b0;
    out_ready2 = 1;
    in_valid2 = 1; in_ctrl2 = 7'h44;
    check("mr_first_ready", 32'(in_ready2), 1);
    exp_q2.push_back(7'h44);
    tick();
    in_valid2 = 0;
    tick(4);

    // ---------------- backpressure, DEPTH=3 ----------------
    out_ready3 = 0;
    in_valid3 = 1;
    for (int k = 1; k <= 3; k++) begin
      in_ctrl3 = 7'(k);
      check("bp_in_ready_fill", 32'(in_ready3), 1);
      exp_q3.push_back(7'(k));
      tick();
    end
    in_ctrl3 = 7'h04;
    check("bp_in_ready_full", 32'(in_ready3), 0);
    check("bp_occ_full",      32'(occupancy3), 3);
    tick();
    check("bp_hold_ready", 32'(in_ready3), 0);
    check("bp_hold_occ",   32'(occupancy3), 3);
    out_ready3 = 1;
    #1;
    check("bp_passthru_ready", 32'(in_ready3), 1);
    exp_q3.push_back(7'h04);
    tick();
    in_valid3 = 0;
    tick(5);
    check("bp_occ_empty", 32'(occupancy3), 0);

    // ---------------- end ----------------
    check("d2_queue_empty", 32'(exp_q2.size()), 0);
    check("d3_queue_empty", 32'(exp_q3.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_ctrl_pipe_stage
